pos_matrix_scan: RTL and testbench



---
 rtl/pos_matrix_scan_if.sv | 26 ++
 rtl/pos_matrix_scan.sv | 88 ++++++++
 tb/tb_pos_matrix_scan.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pos_matrix_scan_if.sv
// Bundle between the position RAM export and the LED matrix scanner.
// The master side supplies the enable and the packed positions.
// The slave side (the scanner) returns the row and column drive and the frame pulse.
interface pos_matrix_scan_if;
  logic        en;
  logic [47:0] pos;
  logic [7:0]  row;
  logic [7:0]  col;
  logic        frame_done;

  modport master (
    output en,
    output pos,
    input  row,
    input  col,
    input  frame_done
  );

  modport slave (
    input  en,
    input  pos,
    output row,
    output col,
    output frame_done
  );
endinterface

// File: rtl/pos_matrix_scan.sv
// pos_matrix_scan: turns the eight packed (row,col) piece positions into a
// row-multiplexed 8x8 LED drive. The position word is snapshotted only at frame
// boundaries (and during reset), so a frame never shows a half-updated board.
// Each row is held for DIV clocks. The columns stay dark for the first BLANK
// clocks of each row to hide ghosting from the previous row.
module pos_matrix_scan #(
  parameter int DIV   = 1000,
  parameter int BLANK = 2
) (
  input  logic             clk,
  input  logic             reset,
  pos_matrix_scan_if.slave bus
);

  localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  row_idx_q, row_idx_d;
  logic [47:0] snap_q, snap_d;
  logic [7:0]  row_q, row_d;
  logic [7:0]  col_q, col_d;
  logic        frame_done_q, frame_done_d;
  logic        blank;
  logic [7:0]  row_cols;

  // With BLANK of zero no clock is blanked, so the compare is left out entirely
  generate
    if (BLANK == 0) begin : g_no_blank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = (cnt_q < 16'(BLANK));
    end
  endgenerate

  // Column pattern of the current row: OR together every piece that sits in it
  always_comb begin
    row_cols = '0;
    for (int i = 0; i < 8; i++) begin
      if (snap_q[47-6*i -: 3] == row_idx_q) begin
        row_cols[snap_q[44-6*i -: 3]] = 1'b1;
      end
    end
  end

  // Next-state for the row counter, snapshot and registered drive outputs
  always_comb begin
    cnt_d        = cnt_q;
    row_idx_d    = row_idx_q;
    snap_d       = snap_q;
    row_d        = 8'h00;
    col_d        = 8'h00;
    frame_done_d = 1'b0;

    if (reset) begin
      cnt_d     = 16'd0;
      row_idx_d = 3'd0;
      snap_d    = bus.pos;
    end else if (bus.en) begin
      row_d = 8'b1 << row_idx_q;
      col_d = blank ? 8'h00 : row_cols;
      if (cnt_q == CNT_LAST) begin
        cnt_d     = 16'd0;
        row_idx_d = row_idx_q + 3'd1;
        if (row_idx_q == 3'd7) begin
          snap_d       = bus.pos;
          frame_done_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // State and output registers; reset is folded into the next-state logic
  always_ff @(posedge clk) begin
    cnt_q        <= cnt_d;
    row_idx_q    <= row_idx_d;
    snap_q       <= snap_d;
    row_q        <= row_d;
    col_q        <= col_d;
    frame_done_q <= frame_done_d;
  end

  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_pos_matrix_scan.sv
// Directed bench for pos_matrix_scan with DIV=4. Two instances run side by side
// from the same stimulus: dut_a blanks one clock per row, dut_b blanks none.
// Expected column patterns per frame are hand-computed 64-bit tables, with
// byte k holding the column drive for row k.
module tb_pos_matrix_scan;

  localparam logic [47:0] POS_ZERO  = 48'h000000000000;
  localparam logic [47:0] POS_DIAG  = 48'h00949B92DDBF;
  localparam logic [47:0] POS_ALL7  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] POS_COLL  = 48'h555000000000;

  localparam logic [63:0] COLS_ZERO = 64'h0000000000000001;
  localparam logic [63:0] COLS_DIAG = 64'h8040201008040201;
  localparam logic [63:0] COLS_ALL7 = 64'h8000000000000000;
  localparam logic [63:0] COLS_COLL = 64'h0000000000200001;

  logic        clk;
  logic        reset;
  logic        en;
  logic [47:0] pos;
  int          total;
  int          bad;

  pos_matrix_scan_if bus_a ();
  pos_matrix_scan_if bus_b ();

  assign bus_a.en  = en;
  assign bus_a.pos = pos;
  assign bus_b.en  = en;
  assign bus_b.pos = pos;

  pos_matrix_scan #(.DIV(4), .BLANK(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  pos_matrix_scan #(.DIV(4), .BLANK(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] row_exp, input logic [7:0] col_a_exp,
                          input logic [7:0] col_b_exp, input logic fd_exp);
    checkOutput({tag, " a.row"}, bus_a.row, row_exp);
    checkOutput({tag, " a.col"}, bus_a.col, col_a_exp);
    checkOutput({tag, " a.fd"}, {7'd0, bus_a.frame_done}, {7'd0, fd_exp});
    checkOutput({tag, " b.row"}, bus_b.row, row_exp);
    checkOutput({tag, " b.col"}, bus_b.col, col_b_exp);
    checkOutput({tag, " b.fd"}, {7'd0, bus_b.frame_done}, {7'd0, fd_exp});
  endtask

  // One full frame of 32 clocks; optional mid-frame pos change, enable gap or reset
  task automatic runFrame(input string name, input logic [63:0] exp_cols, input int change_row,
                          input logic [47:0] change_pos, input int gap_row, input int rst_row);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        logic [7:0] row_exp;
        logic [7:0] col_a_exp;
        logic [7:0] col_b_exp;
        logic       fd_exp;
        if (k == change_row && j == 0) pos = change_pos;
        applyStimulus();
        row_exp   = 8'b1 << k;
        col_b_exp = exp_cols[8*k +: 8];
        col_a_exp = (j == 0) ? 8'h00 : col_b_exp;
        fd_exp    = (k == 7 && j == 3);
        checkAll($sformatf("%s r%0d t%0d", name, k, j), row_exp, col_a_exp, col_b_exp, fd_exp);
        if (k == gap_row && j == 1) begin
          en = 1'b0;
          for (int g = 0; g < 10; g++) begin
            applyStimulus();
            checkAll($sformatf("%s gap%0d", name, g), 8'h00, 8'h00, 8'h00, 1'b0);
          end
          en = 1'b1;
        end
        if (k == rst_row && j == 1) begin
          reset = 1'b1;
          pos   = POS_DIAG;
          applyStimulus();
          checkAll($sformatf("%s midreset", name), 8'h00, 8'h00, 8'h00, 1'b0);
          reset = 1'b0;
          pos   = POS_ALL7;
          return;
        end
      end
    end
  endtask

  // Directed sequence of frames covering each scenario in turn
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    en    = 1'b1;
    pos   = POS_ZERO;

    applyStimulus();
    applyStimulus();
    checkAll("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    reset = 1'b0;

    // All pieces at (0,0); diagonal loaded mid-frame must stay invisible
    runFrame("zero", COLS_ZERO, 2, POS_DIAG, -1, -1);
    // Diagonal; all-(7,7) loaded during row 3
    runFrame("diag", COLS_DIAG, 3, POS_ALL7, -1, -1);
    // All pieces at (7,7); collision pattern loaded during row 4
    runFrame("all7", COLS_ALL7, 4, POS_COLL, -1, -1);
    // Two pieces on (2,5), enable dropped for 10 clocks during row 5
    runFrame("coll", COLS_COLL, 6, POS_ZERO, 5, -1);
    // Zero board, reset during row 6 with the diagonal on pos
    runFrame("zero2", COLS_ZERO, -1, POS_ZERO, -1, 6);
    // Scan restarts at row 0 with the snapshot taken during reset
    runFrame("postrst", COLS_DIAG, -1, POS_ZERO, -1, -1);
    runFrame("final", COLS_ALL7, -1, POS_ZERO, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
